reg_select_file: RTL

REG_SELECT_FILE -- requirements
Module: reg_select_file

---
 rtl/reg_select_file.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/reg_select_file.sv
// Sixteen-entry general register file with IR-field register selection and one-hot bus source selects.
// Also produces the sign-extended IR immediate and a sticky flag for illegal select combinations.
module reg_select_file #(
  parameter int IMM_W = 19
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        BAout,
  input  logic [31:0] BusMuxOut,
  output logic        R0out,
  output logic        R1out,
  output logic        R2out,
  output logic        R3out,
  output logic        R4out,
  output logic        R5out,
  output logic        R6out,
  output logic        R7out,
  output logic        R8out,
  output logic        R9out,
  output logic        R10out,
  output logic        R11out,
  output logic        R12out,
  output logic        R13out,
  output logic        R14out,
  output logic        R15out,
  output logic [31:0] BusMuxIn_R0,
  output logic [31:0] BusMuxIn_R1,
  output logic [31:0] BusMuxIn_R2,
  output logic [31:0] BusMuxIn_R3,
  output logic [31:0] BusMuxIn_R4,
  output logic [31:0] BusMuxIn_R5,
  output logic [31:0] BusMuxIn_R6,
  output logic [31:0] BusMuxIn_R7,
  output logic [31:0] BusMuxIn_R8,
  output logic [31:0] BusMuxIn_R9,
  output logic [31:0] BusMuxIn_R10,
  output logic [31:0] BusMuxIn_R11,
  output logic [31:0] BusMuxIn_R12,
  output logic [31:0] BusMuxIn_R13,
  output logic [31:0] BusMuxIn_R14,
  output logic [31:0] BusMuxIn_R15,
  output logic [31:0] C_sign_extended,
  output logic        sel_err
);

  logic [31:0] regs_reg [16];
  logic        sel_err_reg;
  logic        sel_err_next;
  logic [3:0]  sel_idx;
  logic        sel_valid;
  logic [15:0] decode;
  logic [15:0] rx_out;
  logic        multi_sel;
  logic        unused_ir_bits;

  assign unused_ir_bits = ^IR[31:27];

  // Gra wins over Grb, which wins over Grc
  always_comb begin
    sel_idx   = 4'd0;
    sel_valid = 1'b0;
    if (Gra) begin
      sel_idx   = IR[26:23];
      sel_valid = 1'b1;
    end else if (Grb) begin
      sel_idx   = IR[22:19];
      sel_valid = 1'b1;
    end else if (Grc) begin
      sel_idx   = IR[18:15];
      sel_valid = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_decode
      assign decode[gi] = sel_valid && (sel_idx == 4'(gi));
      assign rx_out[gi] = decode[gi] && (Rout || BAout);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      if (clr) begin
        regs_reg[i] <= 32'h0;
      end else if (Rin && decode[i]) begin
        regs_reg[i] <= BusMuxOut;
      end
    end
  end

  assign multi_sel = (Gra && Grb) || (Gra && Grc) || (Grb && Grc);

  always_comb begin
    sel_err_next = sel_err_reg;
    if ((Rin || Rout || BAout) && (multi_sel || !sel_valid)) begin
      sel_err_next = 1'b1;
    end
    if (Rout && BAout) begin
      sel_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sel_err_reg <= 1'b0;
    end else begin
      sel_err_reg <= sel_err_next;
    end
  end

  assign sel_err         = sel_err_reg;
  assign C_sign_extended = {{(32 - IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]};

  assign R0out  = rx_out[0];
  assign R1out  = rx_out[1];
  assign R2out  = rx_out[2];
  assign R3out  = rx_out[3];
  assign R4out  = rx_out[4];
  assign R5out  = rx_out[5];
  assign R6out  = rx_out[6];
  assign R7out  = rx_out[7];
  assign R8out  = rx_out[8];
  assign R9out  = rx_out[9];
  assign R10out = rx_out[10];
  assign R11out = rx_out[11];
  assign R12out = rx_out[12];
  assign R13out = rx_out[13];
  assign R14out = rx_out[14];
  assign R15out = rx_out[15];

  // A base-address read of R0 yields zero without touching the stored value
  assign BusMuxIn_R0  = BAout ? 32'h0 : regs_reg[0];
  assign BusMuxIn_R1  = regs_reg[1];
  assign BusMuxIn_R2  = regs_reg[2];
  assign BusMuxIn_R3  = regs_reg[3];
  assign BusMuxIn_R4  = regs_reg[4];
  assign BusMuxIn_R5  = regs_reg[5];
  assign BusMuxIn_R6  = regs_reg[6];
  assign BusMuxIn_R7  = regs_reg[7];
  assign BusMuxIn_R8  = regs_reg[8];
  assign BusMuxIn_R9  = regs_reg[9];
  assign BusMuxIn_R10 = regs_reg[10];
  assign BusMuxIn_R11 = regs_reg[11];
  assign BusMuxIn_R12 = regs_reg[12];
  assign BusMuxIn_R13 = regs_reg[13];
  assign BusMuxIn_R14 = regs_reg[14];
  assign BusMuxIn_R15 = regs_reg[15];

endmodule
